// File: rtl/cabac_ctx_init.sv
// CABAC context initialiser: sweeps the init-value ROM once per start and writes
// {pStateIdx, valMps} for every context, derived from slope/offset and the slice QP.
module cabac_ctx_init #(
    parameter int CTX_NUM    = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [5:0]            slice_qp_i,
    output logic                  rom_en_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [15:0]           rom_data_i,
    output logic                  ctx_we_o,
    output logic [ADDR_WIDTH-1:0] ctx_addr_o,
    output logic [6:0]            ctx_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CTX_NUM - 1);
    localparam logic [5:0]            QP_MAX    = 6'd51;

    logic [1:0]            state;
    logic [5:0]            qp;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic signed [7:0]  slope;
    logic signed [7:0]  offset;
    logic signed [14:0] slope_ext;
    logic signed [14:0] qp_ext;
    logic signed [14:0] prod;
    logic signed [14:0] shifted;
    logic signed [15:0] sum;
    logic [6:0]         pre;
    logic [6:0]         ctx_next;

    // Datapath: pre = clip(((m * qp) >>> 4) + n, 1, 126), then split into state/MPS.
    always_comb begin
        slope     = rom_data_i[15:8];
        offset    = rom_data_i[7:0];
        slope_ext = {{7{slope[7]}}, slope};
        qp_ext    = {9'd0, qp};
        prod      = slope_ext * qp_ext;
        shifted   = prod >>> 4;
        sum       = {shifted[14], shifted} + {{8{offset[7]}}, offset};
        if (sum < 16'sd1) begin
            pre = 7'd1;
        end else if (sum > 16'sd126) begin
            pre = 7'd126;
        end else begin
            pre = sum[6:0];
        end
        if (pre <= 7'd63) begin
            ctx_next = {6'(7'd63 - pre), 1'b0};
        end else begin
            ctx_next = {6'(pre - 7'd64), 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            qp         <= 6'd0;
            rom_en_o   <= 1'b0;
            rom_addr_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state      <= READ;
                        qp         <= (slice_qp_i > QP_MAX) ? QP_MAX : slice_qp_i;
                        rom_en_o   <= 1'b1;
                        rom_addr_o <= '0;
                        busy_o     <= 1'b1;
                    end
                end
                READ: begin
                    if (rom_addr_o == LAST_ADDR) begin
                        state    <= DRAIN;
                        rom_en_o <= 1'b0;
                    end else begin
                        rom_addr_o <= rom_addr_o + 1'b1;
                    end
                end
                // The last write is visible on the outputs; finish on the following edge.
                DRAIN: begin
                    if (ctx_we_o && (ctx_addr_o == LAST_ADDR)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // rd_valid marks cycles where rom_data_i answers a read; nothing else is trusted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            ctx_we_o   <= 1'b0;
            ctx_addr_o <= '0;
            ctx_data_o <= 7'd0;
        end else begin
            rd_valid <= rom_en_o;
            rd_addr  <= rom_addr_o;
            ctx_we_o <= rd_valid;
            if (rd_valid) begin
                ctx_addr_o <= rd_addr;
                ctx_data_o <= ctx_next;
            end
        end
    end

endmodule

// File: tb/tb_cabac_ctx_init.sv
// Randomised bench for cabac_ctx_init: a sweep-phase model predicts every output
// each cycle, and the context value comes from plain integer arithmetic.
module tb_cabac_ctx_init;

    localparam int CTX_NUM = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [5:0]  slice_qp_i;
    logic        rom_en_o;
    logic [5:0]  rom_addr_o;
    logic [15:0] rom_data_i;
    logic        ctx_we_o;
    logic [5:0]  ctx_addr_o;
    logic [6:0]  ctx_data_o;
    logic        busy_o;
    logic        done_o;

    logic [15:0] rom [CTX_NUM];
    logic [6:0]  captured [CTX_NUM];

    int pass_count = 0;
    int check_count = 0;
    int phase = -1;
    int sweep_qp = 0;
    int write_count = 0;
    int done_count = 0;
    logic [5:0] hold_addr = 6'd0;
    logic [6:0] hold_data = 7'd0;

    cabac_ctx_init #(.CTX_NUM(64), .ADDR_WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .slice_qp_i (slice_qp_i),
        .rom_en_o   (rom_en_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .ctx_we_o   (ctx_we_o),
        .ctx_addr_o (ctx_addr_o),
        .ctx_data_o (ctx_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM; garbage whenever no read was issued on the previous cycle.
    always @(posedge clk) begin
        if (rom_en_o) rom_data_i <= rom[rom_addr_o];
        else          rom_data_i <= 16'($urandom);
    end

    function automatic logic [6:0] ctx_of(input logic [15:0] w, input int qp);
        int m, n, prod, t, pre;
        m    = int'($signed(w[15:8]));
        n    = int'($signed(w[7:0]));
        prod = m * qp;
        t    = (prod >= 0) ? prod / 16 : -((15 - prod) / 16);
        pre  = t + n;
        if (pre < 1)   pre = 1;
        if (pre > 126) pre = 126;
        if (pre <= 63) return {6'(63 - pre), 1'b0};
        return {6'(pre - 64), 1'b1};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Model: phase k counts edges since the accepting edge; -1 means idle.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                phase     = -1;
                hold_addr = 6'd0;
                hold_data = 7'd0;
            end else if (phase < 0) begin
                if (start_i) begin
                    phase    = 0;
                    sweep_qp = (slice_qp_i > 6'd51) ? 51 : int'(slice_qp_i);
                end
            end else begin
                phase++;
                if (phase > 66) phase = -1;
                if (phase >= 2 && phase <= 65) begin
                    hold_addr = 6'(phase - 2);
                    hold_data = ctx_of(rom[phase - 2], sweep_qp);
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("rom_en", int'(rom_en_o), int'(phase >= 0 && phase <= 63));
            if (phase >= 0 && phase <= 63) checkOutput("rom_addr", int'(rom_addr_o), phase);
            checkOutput("ctx_we", int'(ctx_we_o), int'(phase >= 2 && phase <= 65));
            checkOutput("ctx_addr", int'(ctx_addr_o), int'(hold_addr));
            checkOutput("ctx_data", int'(ctx_data_o), int'(hold_data));
            checkOutput("busy", int'(busy_o), int'(phase >= 0 && phase <= 65));
            checkOutput("done", int'(done_o), int'(phase == 66));
            if (ctx_we_o) begin
                write_count++;
                captured[ctx_addr_o] = ctx_data_o;
            end
            if (done_o) done_count++;
        end
    end

    task automatic fillRom();
        for (int i = 0; i < CTX_NUM; i++) rom[i] = 16'($urandom);
    endtask

    task automatic applyStimulus(input int qp, input bit noise, input bit start_at_done);
        bit seen;
        seen = 1'b0;
        write_count = 0;
        done_count  = 0;
        @(negedge clk);
        start_i    = 1'b1;
        slice_qp_i = 6'(qp);
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (done_o) begin
                seen    = 1'b1;
                start_i = start_at_done;
            end else if (noise) begin
                start_i    = 1'($urandom);
                slice_qp_i = 6'($urandom);
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        @(negedge clk);
        checkOutput("done_seen", int'(seen), 1);
        checkOutput("write_count", write_count, 64);
        checkOutput("done_pulses", done_count, 1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_rom_en"}, int'(rom_en_o), 0);
        checkOutput({name, "_rom_addr"}, int'(rom_addr_o), 0);
        checkOutput({name, "_ctx_we"}, int'(ctx_we_o), 0);
        checkOutput({name, "_ctx_addr"}, int'(ctx_addr_o), 0);
        checkOutput({name, "_ctx_data"}, int'(ctx_data_o), 0);
        checkOutput({name, "_busy"}, int'(busy_o), 0);
        checkOutput({name, "_done"}, int'(done_o), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got20;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        slice_qp_i = 6'd0;
        fillRom();
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        checkOutput("model_fb40_qp26", int'(ctx_of(16'hfb40, 26)), 'h10);
        checkOutput("model_e268_qp51", int'(ctx_of(16'he268, 51)), 'h6e);
        checkOutput("model_0f38_qp51", int'(ctx_of(16'h0f38, 51)), 'h4f);
        checkOutput("model_0f7f_qp51", int'(ctx_of(16'h0f7f, 51)), 'h7d);
        checkOutput("model_ec00_qp51", int'(ctx_of(16'hec00, 51)), 'h7c);
        checkOutput("model_ec60_qp0", int'(ctx_of(16'hec60, 0)), 'h41);

        $display("[TB] full sweep at qp 26");
        rom[7] = 16'hfb40;
        applyStimulus(26, 1'b0, 1'b0);
        checkOutput("sweep_fb40", int'(captured[7]), 'h10);

        $display("[TB] stub words at qp 51");
        fillRom();
        rom[0] = 16'he268;
        rom[1] = 16'h0f38;
        rom[2] = 16'h0f7f;
        rom[3] = 16'hec00;
        applyStimulus(51, 1'b0, 1'b0);
        checkOutput("sweep_e268", int'(captured[0]), 'h6e);
        checkOutput("sweep_0f38", int'(captured[1]), 'h4f);
        checkOutput("sweep_0f7f", int'(captured[2]), 'h7d);
        checkOutput("sweep_ec00", int'(captured[3]), 'h7c);

        $display("[TB] qp 63 clipped to 51, start noise and start with done");
        fillRom();
        rom[10] = 16'he268;
        applyStimulus(63, 1'b1, 1'b1);
        checkOutput("sweep_qp63_e268", int'(captured[10]), 'h6e);
        checkOutput("idle_after_ignored_start", int'(busy_o), 0);

        $display("[TB] reset after 20 writes");
        fillRom();
        write_count = 0;
        done_count  = 0;
        @(negedge clk);
        start_i    = 1'b1;
        slice_qp_i = 6'd30;
        @(negedge clk);
        start_i = 1'b0;
        got20   = 1'b0;
        for (int c = 0; c < 200 && !got20; c++) begin
            if (write_count >= 20) got20 = 1'b1;
            else @(negedge clk);
        end
        checkOutput("reached_20_writes", int'(got20), 1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) @(negedge clk);
        checkOutput("no_done_after_abort", done_count, 0);
        rom[4] = 16'hec60;
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("restart_ec60_qp0", int'(captured[4]), 'h41);

        $display("[TB] random sweeps");
        for (int s = 0; s < 3; s++) begin
            fillRom();
            applyStimulus(int'($urandom_range(0, 63)), 1'b1, 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cabac_ctx_init.md
CABAC_CTX_INIT -- requirements
Module: cabac_ctx_init

Interface
REQ-001 Parameter CTX_NUM, default 64: number of context words swept per initialisation.
REQ-002 Parameter ADDR_WIDTH, default 6: width of ROM and context-memory addresses.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  single-cycle request to start initialisation; sampled only in IDLE.
REQ-006 slice_qp_i  input  6  slice QP, unsigned; latched on an accepted start.
REQ-007 rom_en_o  output  1  read enable to the 16x64 init-value ROM.
REQ-008 rom_addr_o  output  ADDR_WIDTH  ROM read address.
REQ-009 rom_data_i  input  16  ROM word, valid the cycle after rom_en_o; [15:8] = signed slope m, [7:0] = signed offset n.
REQ-010 ctx_we_o  output  1  context-memory write strobe.
REQ-011 ctx_addr_o  output  ADDR_WIDTH  context-memory write address.
REQ-012 ctx_data_o  output  7  initialised context, {pStateIdx[5:0], valMps}.
REQ-013 busy_o  output  1  high while a sweep is in progress.
REQ-014 done_o  output  1  one-cycle pulse when the last context has been written.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-016 IDLE SHALL go to READ on the edge that samples start_i=1, and SHALL latch qp = min(slice_qp_i, 51).
REQ-017 In READ, rom_en_o SHALL be 1 and rom_addr_o SHALL step 0,1,...,CTX_NUM-1 on consecutive cycles, one read per cycle with no gaps.
REQ-018 After the read of address CTX_NUM-1 is issued, READ SHALL go to DRAIN, and rom_en_o SHALL be 0 from then on.
REQ-019 Timing, with E0 as the edge that accepts start: address a is presented after edge E(a); rom_data_i is valid after E(a+1); ctx_we_o, ctx_addr_o = a and ctx_data_o are registered and valid after E(a+2).
REQ-020 A valid bit carried through the pipeline SHALL gate ctx_we_o; rom_data_i SHALL never be used in a cycle that has no read issued on the previous cycle.
REQ-021 Arithmetic: prod = m * qp as a 15-bit signed value; t = prod >>> 4 (arithmetic shift, floor); pre = clip(t + n, 1, 126).
REQ-022 Output mapping: if pre <= 63, valMps = 0 and pStateIdx = 63 - pre; otherwise valMps = 1 and pStateIdx = pre - 64.
REQ-023 DRAIN SHALL go to DONE after the write of address CTX_NUM-1 (edge E(CTX_NUM+1)).
REQ-024 DONE SHALL drive done_o = 1 for exactly one cycle (after E(CTX_NUM+2)) and then return to IDLE.
REQ-025 busy_o SHALL be 1 from after E0 through the cycle of the last write, and 0 in DONE and IDLE.
REQ-026 start_i asserted while not in IDLE SHALL be ignored, with no restart and no change to the latched qp.
REQ-027 start_i in the same cycle as done_o SHALL be ignored; a new start is accepted only in IDLE.
REQ-028 slice_qp_i changes after acceptance SHALL NOT affect the sweep in progress.
REQ-029 ctx_addr_o and ctx_data_o SHALL hold their last values while ctx_we_o = 0.

Reset
REQ-030 rst_n = 0 SHALL immediately force: state IDLE, all outputs 0, address counter 0, pipeline valid bits 0, latched qp 0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep with no further writes and no done_o pulse; the next start SHALL restart from address 0.

Verification
REQ-032 Full sweep with the production ROM: start with qp = 26 -> 64 writes on consecutive cycles, addresses 0..63 in order, first write 2 cycles after the first read, done_o pulse one cycle after the last write. For word 'hfb40: 7'h10 (pre 55, pState 8, mps 0).
REQ-033 Stub ROM words at qp = 51 -> required writes:
  - 'he268 -> 7'h6e (pre 8, pState 55, mps 0)
  - 'h0f38 -> 7'h4f (pre 103, pState 39, mps 1)
REQ-034 QP clip and clip bounds:
  - slice_qp_i = 63 with 'he268 -> 7'h6e (same result as qp 51)
  - 'h0f7f at qp 51 -> pre clipped to 126 -> 7'h7d
  - 'hec00 at qp 51 -> pre clipped to 1 -> 7'h7c
REQ-035 start_i pulsed mid-sweep and again together with done_o -> both ignored; exactly 64 writes; busy_o falls after the last write.
REQ-036 rst_n pulsed low after 20 writes -> outputs 0 at once; no done_o pulse; a new start with qp = 0 -> 'hec60 gives 7'h41 (pre 96, pState 32, mps 1).
REQ-037 ROM driving X whenever rom_en_o was 0 on the previous cycle -> no X appears on ctx_we_o, ctx_addr_o, ctx_data_o, busy_o or done_o.
